// File: rtl/williams2_gun_pkg.sv
// Shared types and helpers for the Williams-2 light-gun ADC emulation.
// - gun_adc_state_t : converter sequencing states
// - GUN_W / ADC_W   : gun position width and conversion result width
// - scale_gun()     : maps a 6-bit gun position onto the 8-bit ADC range
package williams2_gun_pkg;

  localparam int unsigned GUN_W = 6;
  localparam int unsigned ADC_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StConvert,
    StDone
  } gun_adc_state_t;

  // Replicating the top two bits spreads 0..63 evenly over 0x00..0xFF.
  function automatic logic [ADC_W-1:0] scale_gun(input logic [GUN_W-1:0] pos);
    return {pos, pos[GUN_W-1:GUN_W-2]};
  endfunction

endpackage

// File: rtl/williams2_gun_adc_if.sv
// CPU/PIA side bundle for the gun ADC.
// - gun_h, gun_v : gun positions (0..63)
// - adc_sel      : channel select sampled at start (0 = gun_h, 1 = gun_v)
// - adc_start    : one-clock start strobe
// - adc_busy     : conversion in progress
// - adc_eoc      : one-clock end-of-conversion pulse
// - adc_data     : last completed result
// master = PIA/CPU side, slave = converter.
interface williams2_gun_adc_if;

  logic [williams2_gun_pkg::GUN_W-1:0] gun_h;
  logic [williams2_gun_pkg::GUN_W-1:0] gun_v;
  logic                                adc_sel;
  logic                                adc_start;
  logic                                adc_busy;
  logic                                adc_eoc;
  logic [williams2_gun_pkg::ADC_W-1:0] adc_data;

  modport master (
    output gun_h, gun_v, adc_sel, adc_start,
    input  adc_busy, adc_eoc, adc_data
  );

  modport slave (
    input  gun_h, gun_v, adc_sel, adc_start,
    output adc_busy, adc_eoc, adc_data
  );

endinterface

// File: rtl/williams2_sar_step.sv
// One successive-approximation decision against an ideal comparator.
// - trial      : current trial word (bit bit_idx is the bit under test)
// - bit_idx    : bit being decided
// - target     : scaled analogue value being converted
// - trial_next : trial with bit_idx kept/cleared and the next lower bit set
module williams2_sar_step
  import williams2_gun_pkg::*;
(
  input  logic [ADC_W-1:0] trial,
  input  logic [2:0]       bit_idx,
  input  logic [ADC_W-1:0] target,
  output logic [ADC_W-1:0] trial_next
);

  always_comb begin
    trial_next = trial;
    if (trial > target) begin
      trial_next[bit_idx] = 1'b0;
    end
    if (bit_idx != 3'd0) begin
      trial_next[bit_idx - 3'd1] = 1'b1;
    end
  end

endmodule

// File: rtl/williams2_gun_adc.sv
// Emulated light-gun SAR ADC read through the PIA.
// - clock_12 : 12 MHz system clock, rising edge
// - reset    : synchronous, active-high; aborts any conversion without an EOC
// - bus      : williams2_gun_adc_if.slave (positions, select, start, busy, eoc, data)
// A start in IDLE latches the selected position, holds for SAMPLE_CYCLES, then
// decides BITS bits at STEP_CYCLES clocks each. adc_data only changes when the
// full result is ready, together with the one-clock adc_eoc pulse.
module williams2_gun_adc
  import williams2_gun_pkg::*;
#(
  parameter int unsigned BITS          = 8,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned STEP_CYCLES   = 12
) (
  input logic              clock_12,
  input logic              reset,
  williams2_gun_adc_if.slave bus
);

  if (BITS != ADC_W) begin : g_bits_check
    $error("williams2_gun_adc: BITS must equal ADC_W");
  end
  if (SAMPLE_CYCLES < 1 || STEP_CYCLES < 1) begin : g_cycles_check
    $error("williams2_gun_adc: SAMPLE_CYCLES and STEP_CYCLES must be >= 1");
  end

  localparam int unsigned CntMax = (SAMPLE_CYCLES > STEP_CYCLES) ? SAMPLE_CYCLES : STEP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0]  SampleLoad = CntW'(SAMPLE_CYCLES - 1);
  localparam logic [CntW-1:0]  StepLoad   = CntW'(STEP_CYCLES - 1);
  localparam logic [ADC_W-1:0] TrialInit  = {1'b1, {(ADC_W-1){1'b0}}};

  gun_adc_state_t   state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [ADC_W-1:0] trial_q, trial_d;
  logic [GUN_W-1:0] hold_q, hold_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic [ADC_W-1:0] target;
  logic [ADC_W-1:0] trial_next;

  assign target = scale_gun(hold_q);

  williams2_sar_step u_sar_step (
    .trial      (trial_q),
    .bit_idx    (bit_idx_q),
    .target     (target),
    .trial_next (trial_next)
  );

  always_ff @(posedge clock_12) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      trial_q   <= '0;
      hold_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      trial_q   <= trial_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    trial_d   = trial_q;
    hold_d    = hold_q;
    data_d    = data_q;
    case (state_q)
      StIdle: begin
        if (bus.adc_start) begin
          hold_d  = bus.adc_sel ? bus.gun_v : bus.gun_h;
          cnt_d   = SampleLoad;
          state_d = StSample;
        end
      end
      StSample: begin
        if (cnt_q == '0) begin
          bit_idx_d = 3'(BITS - 1);
          trial_d   = TrialInit;
          cnt_d     = StepLoad;
          state_d   = StConvert;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StConvert: begin
        if (cnt_q == '0) begin
          trial_d = trial_next;
          cnt_d   = StepLoad;
          if (bit_idx_q == 3'd0) begin
            // Publish the result on entry to DONE so data and EOC appear together.
            data_d  = trial_next;
            state_d = StDone;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.adc_busy = (state_q == StSample) || (state_q == StConvert);
  assign bus.adc_eoc  = (state_q == StDone);
  assign bus.adc_data = data_q;

endmodule

// File: tb/tb_williams2_gun_adc.sv
// Self-checking bench for williams2_gun_adc: a cycle-level behavioural model
// (timeline since the accepted start plus an arithmetic scaling rule) is compared
// with the DUT every cycle, alongside directed scenarios with literal expectations.
module tb_williams2_gun_adc;
  import williams2_gun_pkg::*;

  localparam int unsigned SampleCycles = 4;
  localparam int unsigned StepCycles   = 12;
  localparam int unsigned Bits         = 8;
  localparam int          Lat          = SampleCycles + Bits * StepCycles + 1;

  logic clock_12 = 1'b0;
  logic reset    = 1'b1;

  williams2_gun_adc_if bus ();

  williams2_gun_adc #(
    .BITS          (Bits),
    .SAMPLE_CYCLES (SampleCycles),
    .STEP_CYCLES   (StepCycles)
  ) dut (
    .clock_12 (clock_12),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_12 = ~clock_12;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int eoc_seen = 0;
  bit chk_en   = 1'b0;

  // Model: m_ph counts edges since the accepted start; the converter is busy for
  // Lat-1 cycles, then shows EOC and the new result for one cycle.
  bit         m_act  = 1'b0;
  int         m_ph   = 0;
  logic [7:0] m_res  = '0;
  logic [7:0] m_data = '0;

  function automatic logic [7:0] ref_scale(input int p);
    return 8'(p * 4 + p / 16);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clock_12) begin
    cyc++;
    if (reset) begin
      m_act  = 1'b0;
      m_ph   = 0;
      m_data = '0;
    end else if (m_act) begin
      m_ph++;
      if (m_ph == Lat - 1) m_data = m_res;
      if (m_ph == Lat) m_act = 1'b0;
    end else if (bus.adc_start) begin
      m_act = 1'b1;
      m_ph  = 0;
      m_res = ref_scale(bus.adc_sel ? int'(bus.gun_v) : int'(bus.gun_h));
    end
  end

  always @(negedge clock_12) begin
    if (chk_en) begin
      check("busy", int'(bus.adc_busy), int'(m_act && m_ph < Lat - 1));
      check("eoc", int'(bus.adc_eoc), int'(m_act && m_ph == Lat - 1));
      check("data", int'(bus.adc_data), int'(m_data));
      if (bus.adc_eoc === 1'b1) eoc_seen++;
    end
  end

  task automatic start_conv(input bit sel, input int h, input int v, output int t);
    @(negedge clock_12);
    bus.gun_h     = 6'(h);
    bus.gun_v     = 6'(v);
    bus.adc_sel   = sel;
    bus.adc_start = 1'b1;
    t = cyc;
    @(negedge clock_12);
    bus.adc_start = 1'b0;
  endtask

  task automatic wait_eoc(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock_12);
      if (bus.adc_eoc === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int t;
    int td;
    int at;
    int e0;

    bus.gun_h     = '0;
    bus.gun_v     = '0;
    bus.adc_sel   = 1'b0;
    bus.adc_start = 1'b0;

    // Reset, then a long idle stretch.
    reset = 1'b1;
    repeat (3) @(negedge clock_12);
    reset  = 1'b0;
    chk_en = 1'b1;
    e0 = eoc_seen;
    repeat (200) @(negedge clock_12);
    #1;
    check("idle_eoc_count", eoc_seen - e0, 0);
    check("idle_busy", int'(bus.adc_busy), 0);
    check("idle_data", int'(bus.adc_data), 8'h00);

    // Mid-scale horizontal: exact timing and value.
    e0 = eoc_seen;
    start_conv(1'b0, 32, 7, t);
    check("busy_at_t1", int'(bus.adc_busy), 1);
    check("busy_at_t1_cyc", cyc - t, 1);
    wait_eoc(200, at);
    check("h32_latency", at - t, 101);
    check("h32_data", int'(bus.adc_data), 8'h82);
    #1;
    check("h32_eoc_count", eoc_seen - e0, 1);

    // Vertical extremes.
    start_conv(1'b1, 0, 63, t);
    wait_eoc(200, at);
    check("v63_latency", at - t, 101);
    check("v63_data", int'(bus.adc_data), 8'hFF);
    start_conv(1'b1, 63, 0, t);
    wait_eoc(200, at);
    check("v0_data", int'(bus.adc_data), 8'h00);

    // Full sweep on both channels with random other-channel values and gaps.
    for (int ch = 0; ch < 2; ch++) begin
      for (int p = 0; p < 64; p++) begin
        int other;
        other = int'($urandom_range(63));
        if (ch == 0) start_conv(1'b0, p, other, t);
        else         start_conv(1'b1, other, p, t);
        wait_eoc(200, at);
        check("sweep_latency", at - t, 101);
        check("sweep_data", int'(bus.adc_data), int'(ref_scale(p)));
        repeat ($urandom_range(3)) @(negedge clock_12);
      end
    end

    // Input changes and a stray start during conversion have no effect.
    e0 = eoc_seen;
    start_conv(1'b0, 10, 3, t);
    repeat (4) @(negedge clock_12);
    bus.gun_h   = 6'd50;
    bus.adc_sel = 1'b1;
    bus.gun_v   = 6'($urandom_range(63));
    repeat (35) @(negedge clock_12);
    check("stray_start_cyc", cyc - t, 40);
    bus.adc_start = 1'b1;
    @(negedge clock_12);
    bus.adc_start = 1'b0;
    wait_eoc(200, at);
    check("hold_latency", at - t, 101);
    check("hold_data", int'(bus.adc_data), 8'h28);
    repeat (30) @(negedge clock_12);
    #1;
    check("hold_eoc_count", eoc_seen - e0, 1);

    // Reset in the middle of a conversion.
    start_conv(1'b0, 32, 0, t);
    wait_eoc(200, at);
    check("pre_reset_data", int'(bus.adc_data), 8'h82);
    start_conv(1'b0, 5, 0, t);
    repeat (59) @(negedge clock_12);
    reset = 1'b1;
    @(negedge clock_12);
    reset = 1'b0;
    check("abort_busy", int'(bus.adc_busy), 0);
    check("abort_data", int'(bus.adc_data), 8'h00);
    e0 = eoc_seen;
    repeat (150) @(negedge clock_12);
    #1;
    check("abort_eoc_count", eoc_seen - e0, 0);

    // Start raised during DONE and held one more cycle: only the second is taken.
    start_conv(1'b0, 20, 0, t);
    wait_eoc(200, at);
    bus.adc_start = 1'b1;
    td = cyc;
    @(negedge clock_12);
    @(negedge clock_12);
    bus.adc_start = 1'b0;
    e0 = eoc_seen;
    wait_eoc(200, at);
    check("done_start_latency", at - td, 102);
    check("done_start_data", int'(bus.adc_data), 8'h51);
    #1;
    check("done_start_eoc_count", eoc_seen - e0, 1);

    // Random traffic: random inputs every cycle, sparse starts and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock_12);
      bus.gun_h     = 6'($urandom);
      bus.gun_v     = 6'($urandom);
      bus.adc_sel   = 1'($urandom);
      bus.adc_start = ($urandom_range(7) == 0);
      reset         = ($urandom_range(499) == 0);
    end
    @(negedge clock_12);
    bus.adc_start = 1'b0;
    reset         = 1'b0;
    repeat (120) @(negedge clock_12);

    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
